iq_tx_deframer: RTL and testbench
=================================

// Module: iq_tx_deframer
// PURPOSE
//  Read-side stage between the TX async FIFO (written by smi_ctrl) and lvds_tx, in the LVDS TX clock domain.
//  Pulls 32-bit I/Q words and checks the modem sync pattern: I sync [31:30]=2'b10, Q sync [15:14]=2'b01.
//  Drops malformed words and presents valid words to lvds_tx through a valid/ready handshake.
//  On FIFO underrun, optionally inserts a zero-sample frame and counts errors for SPI status readback.
// PARAMETERS
//  CHECK_SYNC   1             1: enforce sync bits; 0: pass every word unchanged
//  ZERO_WORD    32'h8000_4000 frame emitted on underrun (sync bits set, I=Q=0)
//  CNT_W        16            width of the saturating status counters
// PORTS
//  i_sys_clk          in   1      block clock (LVDS TX word clock)
//  i_rst_b            in   1      asynchronous, active-low reset
//  i_enable           in   1      streaming enable (level)
//  i_zero_on_underrun in   1      1: insert ZERO_WORD on underrun; 0: deassert valid
//  i_fifo_empty       in   1      TX FIFO empty
//  i_fifo_data        in   32     TX FIFO read data, valid the cycle after a pull
//  o_fifo_pull        out  1      one-cycle read strobe to the TX FIFO
//  o_tx_data          out  32     word to lvds_tx
//  o_tx_valid         out  1      o_tx_data holds a word
//  i_tx_ready         in   1      lvds_tx consumes the word this cycle when valid&ready
//  o_sync_err_cnt     out  CNT_W  dropped malformed words, saturating
//  o_underrun_cnt     out  CNT_W  underrun insertions or bubbles, saturating
//  o_active           out  1      FSM not in IDLE
// BEHAVIOUR
//  Reset (async, i_rst_b=0):
//   - All outputs 0, o_tx_data=0, counters 0, FSM=IDLE, prefetch buffer empty.
//  Pipeline:
//   - Stage F: pull when !i_fifo_empty and the prefetch slot is free or freeing this cycle.
//     Never pull when empty.
//   - Stage C, next cycle: capture i_fifo_data and check sync. Good words go to the prefetch slot.
//     Bad words are dropped and o_sync_err_cnt increments.
//   - Output register loads from the prefetch slot when !o_tx_valid or on a valid&ready handshake.
//   - Latency: pull-to-o_tx_valid is 2 cycles; sustained 1 word/cycle when the FIFO is non-empty.
//  FSM:
//   - IDLE: no pulls, o_tx_valid=0. Go to PRIME when i_enable=1.
//   - PRIME: fill the pipeline. Stay until the first good word reaches the output register, then go to RUN.
//     Empty FIFO in PRIME is not an underrun.
//   - RUN: on a handshake with no good word ready, it is an underrun and o_underrun_cnt increments.
//     If i_zero_on_underrun=1, o_tx_data=ZERO_WORD and o_tx_valid stays 1.
//     Otherwise o_tx_valid=0 until the next good word.
//   - DRAIN: entered when i_enable drops in PRIME or RUN. No new pulls; an in-flight pulled word is still
//     captured and delivered. No underrun counting. Go to IDLE when the output and the prefetch slot are
//     empty, or after the in-flight word is delivered.
//  Boundaries:
//   - Counters saturate at all-ones and clear only on reset.
//   - A held word stays stable while o_tx_valid & !i_tx_ready.
//   - i_enable re-asserted during DRAIN: finish DRAIN, pass through IDLE for 1 cycle, then PRIME.
//   - ZERO_WORD being held is replaced by a real word only after it is consumed.
//   - CHECK_SYNC=0: no word is dropped and o_sync_err_cnt stays 0.
//   - Reset mid-stream discards all buffered words immediately. A pull strobe in flight is not completed.
// STRUCTURE
//  Shared package/header:
//   - Sync constants: I_SYNC=2'b10, Q_SYNC=2'b01, bit positions.
//   - ZERO_WORD default and FSM state encodings (IDLE/PRIME/RUN/DRAIN, 2 bits).
//   - lvds_tx and rx_framer use the same sync constants.
//  One sub-module: iq_sync_check, combinational. Takes the 32-bit word and returns sync_ok.
//  Prefetch slot, output register, counters and FSM live in the top of this block.
// TESTING
//  1. Reset, then enable; push 4 good words 0x8001_4002..0x8004_4005; ready=1.
//     Expect the 4 words in order, first valid 2 cycles after the first pull, no counter change.
//  2. Push 0x8001_4002, 0x0001_4002 (bad I sync), 0x8003_4004.
//     Expect the 1st and 3rd out; o_sync_err_cnt=1.
//  3. RUN with ready=1, FIFO goes empty for 3 cycles, zero_on_underrun=1.
//     Expect 3 consecutive 0x8000_4000 outputs; o_underrun_cnt=3.
//     Repeat with zero_on_underrun=0: valid low 3 cycles, count still 3.
//  4. Backpressure: ready=0 for 5 cycles with valid high.
//     Expect o_tx_data stable, at most 2 words pulled, no drops.
//  5. Drop i_enable with a word in flight.
//     Expect the word delivered, no further pulls, o_active=0 within 4 cycles, no underrun counted.
//  6. Assert i_rst_b=0 mid-stream.
//     Expect o_tx_valid, o_fifo_pull and counters all 0 immediately (async), FSM IDLE.

Source files
------------

// File: rtl/iq_tx_deframer_pkg.sv
// Shared constants for the TX I/Q word path: modem sync pattern, underrun fill word and
// deframer FSM encoding. lvds_tx and rx_framer reuse the same sync definitions.
package iq_tx_deframer_pkg;

   localparam logic [1:0]  I_SYNC        = 2'b10;
   localparam logic [1:0]  Q_SYNC        = 2'b01;
   localparam int unsigned I_SYNC_HI     = 31;
   localparam int unsigned I_SYNC_LO     = 30;
   localparam int unsigned Q_SYNC_HI     = 15;
   localparam int unsigned Q_SYNC_LO     = 14;
   localparam logic [31:0] ZERO_WORD_DEF = 32'h8000_4000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_PRIME = 2'b01,
      ST_RUN   = 2'b10,
      ST_DRAIN = 2'b11
   } state_e;

   function automatic logic sync_match(input logic [1:0] i_bits, input logic [1:0] q_bits);
      return (i_bits == I_SYNC) && (q_bits == Q_SYNC);
   endfunction

endpackage

// File: rtl/iq_tx_deframer_sync_check.sv
// Combinational sync-pattern check for one 32-bit I/Q word; with CHECK_SYNC=0 every word is accepted.
module iq_sync_check
   import iq_tx_deframer_pkg::*;
#(
   parameter bit CHECK_SYNC = 1'b1
) (
   input  logic [31:0] word,
   output logic        sync_ok
);

   logic unused_bits_s;

   assign unused_bits_s = ^{word[29:16], word[13:0]};

   // Sync decision for the word captured from the FIFO this cycle.
   always_comb begin
      if (CHECK_SYNC) begin
         sync_ok = sync_match(word[I_SYNC_HI:I_SYNC_LO], word[Q_SYNC_HI:Q_SYNC_LO]);
      end else begin
         sync_ok = 1'b1;
      end
   end

endmodule

// File: rtl/iq_tx_deframer.sv
// Read side of the TX async FIFO: pulls I/Q words, drops words with a broken sync pattern and
// hands good words to lvds_tx over valid/ready, filling underruns with a zero frame or a bubble.
module iq_tx_deframer
   import iq_tx_deframer_pkg::*;
#(
   parameter bit          CHECK_SYNC = 1'b1,
   parameter logic [31:0] ZERO_WORD  = ZERO_WORD_DEF,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             i_sys_clk,
   input  logic             i_rst_b,
   input  logic             i_enable,
   input  logic             i_zero_on_underrun,
   input  logic             i_fifo_empty,
   input  logic [31:0]      i_fifo_data,
   output logic             o_fifo_pull,
   output logic [31:0]      o_tx_data,
   output logic             o_tx_valid,
   input  logic             i_tx_ready,
   output logic [CNT_W-1:0] o_sync_err_cnt,
   output logic [CNT_W-1:0] o_underrun_cnt,
   output logic             o_active
);

   state_e           state_r, state_s;
   logic             pull_r, pull_s;
   logic             pf_valid_r, pf_valid_s;
   logic [31:0]      pf_data_r, pf_data_s;
   logic             out_valid_r, out_valid_s;
   logic [31:0]      out_data_r, out_data_s;
   logic [CNT_W-1:0] sync_err_cnt_r, underrun_cnt_r;
   logic             sync_ok_s, in_good_s, in_bad_s, take_s, underrun_s;

   iq_sync_check #(
      .CHECK_SYNC (CHECK_SYNC)
   ) u_sync_check (
      .word    (i_fifo_data),
      .sync_ok (sync_ok_s)
   );

   assign in_good_s = pull_r & sync_ok_s;
   assign in_bad_s  = pull_r & ~sync_ok_s;
   assign take_s    = ~out_valid_r | i_tx_ready;

   // Output register and prefetch slot; a fresh good word bypasses the slot when the output can take it.
   always_comb begin
      out_valid_s = out_valid_r;
      out_data_s  = out_data_r;
      pf_valid_s  = pf_valid_r;
      pf_data_s   = pf_data_r;
      underrun_s  = 1'b0;
      if (take_s) begin
         if (pf_valid_r) begin
            out_valid_s = 1'b1;
            out_data_s  = pf_data_r;
            pf_valid_s  = in_good_s;
            if (in_good_s) begin
               pf_data_s = i_fifo_data;
            end else begin
               pf_data_s = pf_data_r;
            end
         end else if (in_good_s) begin
            out_valid_s = 1'b1;
            out_data_s  = i_fifo_data;
         end else if (state_r == ST_RUN) begin
            underrun_s = 1'b1;
            if (i_zero_on_underrun) begin
               out_valid_s = 1'b1;
               out_data_s  = ZERO_WORD;
            end else begin
               out_valid_s = 1'b0;
            end
         end else begin
            out_valid_s = 1'b0;
         end
      end else if (in_good_s) begin
         pf_valid_s = 1'b1;
         pf_data_s  = i_fifo_data;
      end else begin
         pf_valid_s = pf_valid_r;
      end
   end

   // A pull is issued only if the slot is guaranteed free when its data lands next cycle.
   always_comb begin
      if (((state_r == ST_PRIME) || (state_r == ST_RUN)) && i_enable && !i_fifo_empty && !pf_valid_s) begin
         pull_s = 1'b1;
      end else begin
         pull_s = 1'b0;
      end
   end

   // Next-state logic for the streaming FSM.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (i_enable) begin
               state_s = ST_PRIME;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_PRIME: begin
            if (!i_enable) begin
               state_s = ST_DRAIN;
            end else if (out_valid_s) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_PRIME;
            end
         end
         ST_RUN: begin
            if (!i_enable) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (!out_valid_s && !pf_valid_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, pipeline registers and saturating status counters.
   always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         state_r        <= ST_IDLE;
         pull_r         <= 1'b0;
         pf_valid_r     <= 1'b0;
         pf_data_r      <= 32'h0000_0000;
         out_valid_r    <= 1'b0;
         out_data_r     <= 32'h0000_0000;
         sync_err_cnt_r <= {CNT_W{1'b0}};
         underrun_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r     <= state_s;
         pull_r      <= pull_s;
         pf_valid_r  <= pf_valid_s;
         pf_data_r   <= pf_data_s;
         out_valid_r <= out_valid_s;
         out_data_r  <= out_data_s;
         if (in_bad_s && (sync_err_cnt_r != {CNT_W{1'b1}})) begin
            sync_err_cnt_r <= sync_err_cnt_r + CNT_W'(1);
         end else begin
            sync_err_cnt_r <= sync_err_cnt_r;
         end
         if (underrun_s && (underrun_cnt_r != {CNT_W{1'b1}})) begin
            underrun_cnt_r <= underrun_cnt_r + CNT_W'(1);
         end else begin
            underrun_cnt_r <= underrun_cnt_r;
         end
      end
   end

   assign o_fifo_pull    = pull_s;
   assign o_tx_data      = out_data_r;
   assign o_tx_valid     = out_valid_r;
   assign o_sync_err_cnt = sync_err_cnt_r;
   assign o_underrun_cnt = underrun_cnt_r;
   assign o_active       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_iq_tx_deframer.sv
// Self-checking bench for iq_tx_deframer: the bench acts as the TX FIFO and keeps an in-order
// queue of good words that every valid&ready handshake must match.
module tb_iq_tx_deframer;

   localparam logic [31:0] ZW = 32'h8000_4000;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        enable = 1'b0;
   logic        zmode = 1'b0;
   logic        fifo_empty = 1'b1;
   logic [31:0] fifo_data = 32'h0000_0000;
   logic        fifo_pull;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [15:0] sync_err_cnt;
   logic [15:0] underrun_cnt;
   logic        active;

   iq_tx_deframer dut (
      .i_sys_clk          (clk),
      .i_rst_b            (rst_b),
      .i_enable           (enable),
      .i_zero_on_underrun (zmode),
      .i_fifo_empty       (fifo_empty),
      .i_fifo_data        (fifo_data),
      .o_fifo_pull        (fifo_pull),
      .o_tx_data          (tx_data),
      .o_tx_valid         (tx_valid),
      .i_tx_ready         (tx_ready),
      .o_sync_err_cnt     (sync_err_cnt),
      .o_underrun_cnt     (underrun_cnt),
      .o_active           (active)
   );

   always #5 clk = ~clk;

   logic [31:0] fifo_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] deliv_log[$];
   int  checks = 0, errors = 0;
   int  cyc = 0, bad_cnt = 0, n_deliv = 0, n_zero = 0, n_pull = 0, n_vlow = 0;
   int  first_pull_cyc = -1, first_valid_cyc = -1;
   bit  pend_pop = 1'b0, prev_hold = 1'b0, zero_ok = 1'b0;
   bit  rdy_v = 1'b1, en_v = 1'b0, zm_v = 1'b0, hold_empty = 1'b0;
   logic [31:0] prev_data = 32'h0000_0000;

   function automatic bit good_word(input logic [31:0] w);
      return (w[31:30] == 2'b10) && (w[15:14] == 2'b01);
   endfunction

   function automatic logic [31:0] rand_word(input bit good);
      logic [31:0] w;
      w = $urandom;
      w[31:30] = 2'b10;
      w[15:14] = 2'b01;
      w[0]     = 1'b1;
      if (!good) begin
         case ($urandom_range(2, 0))
            0:       w[31] = 1'b0;
            1:       w[14] = 1'b0;
            default: begin w[30] = 1'b1; w[15] = 1'b1; end
         endcase
      end
      return w;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_model();
      fifo_q.delete();
      exp_q.delete();
      deliv_log.delete();
      bad_cnt = 0; n_deliv = 0; n_zero = 0; n_pull = 0; n_vlow = 0;
      first_pull_cyc = -1; first_valid_cyc = -1;
      pend_pop = 1'b0; prev_hold = 1'b0;
   endtask

   // One clock: drive inputs at the falling edge, then check the settled outputs against the model.
   task automatic step();
      logic [31:0] w, e;
      @(negedge clk);
      cyc++;
      if (pend_pop) begin
         w = fifo_q.pop_front();
         fifo_data = w;
         if (good_word(w)) exp_q.push_back(w);
         else bad_cnt++;
         pend_pop = 1'b0;
      end
      tx_ready   = rdy_v;
      enable     = en_v;
      zmode      = zm_v;
      fifo_empty = hold_empty || (fifo_q.size() == 0);
      #1;
      if (prev_hold) begin
         chk("hold_valid", {31'd0, tx_valid}, 32'd1);
         chk("hold_data", tx_data, prev_data);
      end
      if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (!tx_valid) n_vlow++;
      if (tx_valid && tx_ready) begin
         if (zero_ok && tx_data == ZW) begin
            n_zero++;
         end else if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word: got %h expected no delivery (cycle %0d)", tx_data, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("tx_data", tx_data, e);
            deliv_log.push_back(tx_data);
            n_deliv++;
         end
      end
      checks++;
      if (int'(sync_err_cnt) > bad_cnt) begin
         errors++;
         $display("FAIL sync_err_bound: got %0d expected at most %0d (cycle %0d)", sync_err_cnt, bad_cnt, cyc);
      end
      if (fifo_pull) begin
         n_pull++;
         if (first_pull_cyc < 0) first_pull_cyc = cyc;
         if (fifo_empty) begin
            checks++; errors++;
            $display("FAIL pull_when_empty: got pull=1 expected 0 (cycle %0d)", cyc);
         end else begin
            pend_pop = 1'b1;
         end
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      clear_model();
      en_v = 1'b0; rdy_v = 1'b1; zm_v = 1'b0; hold_empty = 1'b0; zero_ok = 1'b0;
      repeat (2) step();
      rst_b = 1'b1;
      step();
   endtask

   task automatic wait_deliv(input int n, input int bound);
      int k;
      k = 0;
      while (n_deliv < n && k < bound) begin
         step();
         k++;
      end
      chk("deliv_count", n_deliv, n);
   endtask

   task automatic wait_idle(input int bound, output int used);
      used = 0;
      while (active && used < bound) begin
         step();
         used++;
      end
      chk("idle_reached", {31'd0, active}, 32'd0);
   endtask

   task automatic random_phase(input bit zm, input int nwords, input int ncyc);
      int used;
      do_reset();
      zm_v = zm; zero_ok = zm;
      for (int i = 0; i < nwords; i++) fifo_q.push_back(rand_word($urandom_range(9, 0) < 8));
      en_v = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         rdy_v      = ($urandom_range(9, 0) < 7);
         hold_empty = ($urandom_range(7, 0) == 0);
         en_v       = ($urandom_range(39, 0) != 0);
         step();
      end
      rdy_v = 1'b1; hold_empty = 1'b0; en_v = 1'b0;
      wait_idle(40, used);
      step();
      chk("rand_exp_drained", exp_q.size(), 32'd0);
      chk("rand_sync_err", {16'd0, sync_err_cnt}, bad_cnt);
   endtask

   initial begin
      int u0, z0, v0, p0, used;

      // Reset values
      do_reset();
      chk("rst_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_data", tx_data, 32'h0000_0000);
      chk("rst_pull", {31'd0, fifo_pull}, 32'd0);
      chk("rst_err_cnt", {16'd0, sync_err_cnt}, 32'd0);
      chk("rst_und_cnt", {16'd0, underrun_cnt}, 32'd0);
      chk("rst_active", {31'd0, active}, 32'd0);

      // Test 1: prime on an empty FIFO, then four good words
      en_v = 1'b1;
      repeat (5) step();
      chk("prime_active", {31'd0, active}, 32'd1);
      chk("prime_no_pull", first_pull_cyc, -1);
      for (int i = 0; i < 4; i++) fifo_q.push_back(32'h8001_4002 + 32'h0001_0001 * i);
      wait_deliv(4, 30);
      chk("t1_first_word", deliv_log[0], 32'h8001_4002);
      chk("t1_last_word", deliv_log[3], 32'h8004_4005);
      chk("t1_latency", first_valid_cyc - first_pull_cyc, 32'd2);
      chk("t1_und_cnt", {16'd0, underrun_cnt}, 32'd0);
      chk("t1_err_cnt", {16'd0, sync_err_cnt}, 32'd0);

      // Test 2: a word with broken I sync is dropped
      do_reset();
      fifo_q.push_back(32'h8001_4002);
      fifo_q.push_back(32'h0001_4002);
      fifo_q.push_back(32'h8003_4004);
      en_v = 1'b1;
      wait_deliv(2, 30);
      repeat (3) step();
      chk("t2_err_cnt", {16'd0, sync_err_cnt}, 32'd1);
      chk("t2_word0", deliv_log[0], 32'h8001_4002);
      chk("t2_word1", deliv_log[1], 32'h8003_4004);
      chk("t2_deliv", n_deliv, 32'd2);
      en_v = 1'b0;
      wait_idle(10, used);

      // Test 3: three-cycle FIFO gap in RUN, zero insertion then bubbles
      do_reset();
      zm_v = 1'b1; zero_ok = 1'b1;
      for (int i = 0; i < 60; i++) fifo_q.push_back(rand_word(1'b1));
      en_v = 1'b1;
      repeat (10) step();
      u0 = underrun_cnt; z0 = n_zero;
      hold_empty = 1'b1;
      repeat (3) step();
      hold_empty = 1'b0;
      repeat (8) step();
      chk("t3_zero_und", underrun_cnt - u0, 32'd3);
      chk("t3_zero_words", n_zero - z0, 32'd3);
      chk("t3_zero_und_abs", {16'd0, underrun_cnt}, 32'd3);
      zm_v = 1'b0;
      repeat (2) step();
      u0 = underrun_cnt; v0 = n_vlow;
      hold_empty = 1'b1;
      repeat (3) step();
      hold_empty = 1'b0;
      repeat (8) step();
      chk("t3_bubble_und", underrun_cnt - u0, 32'd3);
      chk("t3_bubble_low", n_vlow - v0, 32'd3);

      // Test 6: asynchronous reset in the middle of the stream
      step();
      #2;
      rst_b = 1'b0;
      #1;
      chk("t6_valid", {31'd0, tx_valid}, 32'd0);
      chk("t6_pull", {31'd0, fifo_pull}, 32'd0);
      chk("t6_und_cnt", {16'd0, underrun_cnt}, 32'd0);
      chk("t6_err_cnt", {16'd0, sync_err_cnt}, 32'd0);
      chk("t6_active", {31'd0, active}, 32'd0);
      chk("t6_data", tx_data, 32'h0000_0000);
      clear_model();
      en_v = 1'b0; hold_empty = 1'b0;
      step();
      rst_b = 1'b1;
      step();

      // Test 4: backpressure for five cycles
      do_reset();
      for (int i = 0; i < 30; i++) fifo_q.push_back(rand_word(1'b1));
      en_v = 1'b1;
      repeat (8) step();
      p0 = n_pull;
      rdy_v = 1'b0;
      repeat (5) step();
      checks++;
      if (n_pull - p0 > 2) begin
         errors++;
         $display("FAIL t4_bp_pulls: got %0d expected at most 2", n_pull - p0);
      end
      rdy_v = 1'b1;
      repeat (5) step();
      chk("t4_err_cnt", {16'd0, sync_err_cnt}, 32'd0);

      // Test 5: enable dropped with a word in flight
      p0 = n_pull; u0 = underrun_cnt;
      en_v = 1'b0;
      wait_idle(8, used);
      checks++;
      if (used > 4) begin
         errors++;
         $display("FAIL t5_idle_time: got %0d cycles expected at most 4", used);
      end
      chk("t5_no_pulls", n_pull - p0, 32'd0);
      chk("t5_und_cnt", underrun_cnt - u0, 32'd0);
      chk("t5_drained", exp_q.size(), 32'd0);

      // Randomized streams
      random_phase(1'b0, 300, 400);
      random_phase(1'b1, 300, 400);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
